// File: rtl/aim65_display_ctl.sv
// aim65_display_ctl
//   Bridge from the AIM-65 alphanumeric display chip selects to the character
//   video RAM of the text renderer. Each digit write becomes one framed video
//   RAM write (SETUP, WE1, WE2, HOLD). Writing the leftmost digit (col 0)
//   advances the line pointer first; once the screen has wrapped, every new
//   line pulses vscroll and moves scroll_row down one row.
//
//   Optional feature: define AIM65_DISP_CLEAR_FILL_EN to make a clear also
//   fill the whole video RAM with spaces (8'h20), one address per 2 cycles.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   ce_n[NUM_CHIPS]     display chip enables, active low, index 0 leftmost
//   w_n                 write strobe, active low
//   daddr[2]            digit select, 3 = leftmost digit of a chip
//   ddata[8]            character data (bit 7 discarded)
//   video_clear         clear request level, acted on at its rising edge
//   vram_addr/data      video RAM address / write data
//   vram_ce, vram_we    video RAM enable / write enable
//   busy                write frame or clear fill in progress
//   vscroll             one-cycle pulse, renderer scrolls one row
//   scroll_row          row shown at the top of the screen
//   drop_cnt            saturating count of discarded writes
module aim65_display_ctl #(
  parameter int NUM_CHIPS = 5,
  parameter int COLS      = 40,
  parameter int ROWS      = 25,
  parameter int ADDR_W    = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CHIPS-1:0]     ce_n,
  input  logic                     w_n,
  input  logic [1:0]               daddr,
  input  logic [7:0]               ddata,
  input  logic                     video_clear,
  output logic [ADDR_W-1:0]        vram_addr,
  output logic [7:0]               vram_data,
  output logic                     vram_ce,
  output logic                     vram_we,
  output logic                     busy,
  output logic                     vscroll,
  output logic [$clog2(ROWS)-1:0]  scroll_row,
  output logic [7:0]               drop_cnt
);
  localparam int RW  = $clog2(ROWS);
  localparam int TOT = COLS * ROWS;

  typedef struct packed {
    logic [4:0] col;
    logic [7:0] data;
  } wr_req_t;

  typedef enum logic [2:0] {IDLE, SETUP, WE1, WE2, HOLD, FILL} state_t;

  state_t      state, state_n;
  logic [2:0]  chip;
  logic        wact;
  logic [1:0]  wact_pipe, clr_pipe;
  wr_req_t     cap, pend, ld;
  logic        pend_full, clr_pend;
  logic        evt, clr_evt, clr_now, slot_vld;
  logic        do_load, take, do_clear, slot_store, drop;

  logic [ADDR_W-1:0] row_base, base_e, base_n, addr_n;
  logic [ADDR_W:0]   sum;
  logic [RW-1:0]     row_idx, row_e, row_n, srow_e, srow_n;
  logic              wrapped, wrp_e, wrap_n, vs;

`ifdef AIM65_DISP_CLEAR_FILL_EN
  logic fill_ph;
`endif

  // lowest-numbered enabled chip wins
  always_comb begin
    chip = '0;
    for (int i = NUM_CHIPS - 1; i >= 0; i--)
      if (!ce_n[i]) chip = 3'(i);
  end

  assign wact    = !w_n && (ce_n != '1);
  assign evt     = wact_pipe[0] & ~wact_pipe[1];
  assign clr_evt = clr_pipe[0] & ~clr_pipe[1];
  assign busy    = (state != IDLE);
  assign vram_ce = (state != IDLE);
`ifdef AIM65_DISP_CLEAR_FILL_EN
  assign vram_we = (state == WE1) || (state == WE2) || (state == FILL && fill_ph);
`else
  assign vram_we = (state == WE1) || (state == WE2);
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    do_load  = 1'b0;
    take     = 1'b0;
    do_clear = 1'b0;
    clr_now  = clr_evt | clr_pend;
    // a clear edge flushes the slot immediately; pointers reset once idle
    slot_vld = pend_full & ~clr_evt;
    case (state)
      IDLE: begin
        do_clear = clr_now;
        if (slot_vld) begin
          take    = 1'b1;
          do_load = 1'b1;
        end else if (evt) begin
          do_load = 1'b1;
        end
        if (do_load) state_n = SETUP;
`ifdef AIM65_DISP_CLEAR_FILL_EN
        if (clr_now) begin
          take    = 1'b0;
          do_load = 1'b0;
          state_n = FILL;
        end
`endif
      end
      SETUP: state_n = WE1;
      WE1:   state_n = WE2;
      WE2:   state_n = HOLD;
      HOLD: begin
        state_n = IDLE;
        // chain the next frame straight after HOLD unless a clear waits
        if (!clr_now) begin
          if (slot_vld) begin
            take    = 1'b1;
            do_load = 1'b1;
          end else if (evt) begin
            do_load = 1'b1;
          end
          if (do_load) state_n = SETUP;
        end
      end
`ifdef AIM65_DISP_CLEAR_FILL_EN
      FILL: if (fill_ph && vram_addr == ADDR_W'(TOT - 1)) state_n = IDLE;
`endif
      default: state_n = IDLE;
    endcase
    // an event not taken directly goes to the slot; the slot is only freed
    // for it when IDLE consumes the old entry in the same cycle
    slot_store = evt & ~(do_load & ~take) & (~slot_vld | (take & (state == IDLE)));
    drop       = evt & ~(do_load & ~take) & ~slot_store;
  end

  // pointer arithmetic for the entry being loaded
  always_comb begin
    base_e = do_clear ? '0 : row_base;
    wrp_e  = do_clear ? 1'b0 : wrapped;
    row_e  = do_clear ? '0 : row_idx;
    srow_e = do_clear ? '0 : scroll_row;
    ld     = take ? pend : cap;
    sum    = {1'b0, base_e} + (ADDR_W + 1)'(COLS);
    base_n = base_e;
    row_n  = row_e;
    wrap_n = wrp_e;
    srow_n = srow_e;
    vs     = 1'b0;
    addr_n = base_e + ADDR_W'(ld.col);
    if (ld.col == '0) begin
      if (sum == (ADDR_W + 1)'(TOT)) begin
        base_n = '0;
        row_n  = '0;
        wrap_n = 1'b1;
      end else begin
        base_n = sum[ADDR_W-1:0];
        row_n  = row_e + 1'b1;
      end
      addr_n = base_n;
      if (wrap_n) begin
        vs     = 1'b1;
        srow_n = (row_n == RW'(ROWS - 1)) ? '0 : row_n + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wact_pipe  <= '0;
      clr_pipe   <= '0;
      cap        <= '0;
      pend       <= '0;
      pend_full  <= 1'b0;
      clr_pend   <= 1'b0;
      row_base   <= '0;
      row_idx    <= '0;
      wrapped    <= 1'b0;
      scroll_row <= '0;
      vscroll    <= 1'b0;
      vram_addr  <= '0;
      vram_data  <= '0;
      drop_cnt   <= '0;
`ifdef AIM65_DISP_CLEAR_FILL_EN
      fill_ph    <= 1'b0;
`endif
    end else begin
      wact_pipe <= {wact_pipe[0], wact};
      clr_pipe  <= {clr_pipe[0], video_clear};
      cap.col   <= {chip, ~daddr};  // 4*chip + (3 - daddr)
      cap.data  <= ddata & 8'h7F;
      vscroll   <= 1'b0;
      if (do_load) begin
        row_base   <= base_n;
        row_idx    <= row_n;
        wrapped    <= wrap_n;
        scroll_row <= srow_n;
        vscroll    <= vs;
        vram_addr  <= addr_n;
        vram_data  <= ld.data;
      end else if (do_clear) begin
        row_base   <= '0;
        row_idx    <= '0;
        wrapped    <= 1'b0;
        scroll_row <= '0;
      end
      clr_pend <= (clr_pend | clr_evt) & ~do_clear;
      if (take | clr_evt) pend_full <= 1'b0;
      if (slot_store) begin
        pend_full <= 1'b1;
        pend      <= cap;
      end
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
`ifdef AIM65_DISP_CLEAR_FILL_EN
      if (state == IDLE && state_n == FILL) begin
        vram_addr <= '0;
        vram_data <= 8'h20;
        fill_ph   <= 1'b0;
      end else if (state == FILL) begin
        fill_ph <= ~fill_ph;
        if (fill_ph && vram_addr != ADDR_W'(TOT - 1)) vram_addr <= vram_addr + 1'b1;
      end
`endif
    end
  end

endmodule
